// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer: owns PC, IR and NZP, drives ALU selects.
// Ports: clk/rst, imem req/addr/ack/rdata, ALU selects, rf indices/we, flags, cc, halted, illegal.
module cpu_control_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [1:0]  alu_op,
  output logic [1:0]  source_sel,
  output logic [5:0]  ins_immediate,
  output logic [5:0]  pc,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  output logic [2:0]  rf_dr,
  output logic        rf_we,
  input  logic        negative,
  input  logic        zero,
  input  logic        positive,
  output logic [2:0]  cc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [3:0]  opc;
  logic        we_q;
  logic        ill_q;
  logic        br_taken;

  logic [1:0]  dec_op;
  logic [1:0]  dec_src;
  logic        dec_we;
  logic        dec_ill;

  assign opc = ir[15:12];

  always_comb begin
    dec_op  = 2'b00;
    dec_src = 2'b00;
    dec_we  = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      4'b0001: begin
        dec_op  = 2'b00;
        dec_src = ir[5] ? 2'b00 : 2'b10;
        dec_we  = 1'b1;
      end
      4'b0101: begin
        dec_op  = 2'b01;
        dec_src = ir[5] ? 2'b00 : 2'b10;
        dec_we  = 1'b1;
      end
      4'b1001: begin
        dec_op  = 2'b10;
        dec_src = ir[5] ? 2'b00 : 2'b10;
        dec_we  = 1'b1;
      end
      4'b1110: begin
        dec_op  = 2'b00;
        dec_src = 2'b01;
        dec_we  = 1'b1;
      end
      4'b0000, 4'b1111: ;
      default: dec_ill = 1'b1;
    endcase
  end

  // cc seen here is still the previous instruction's value
  assign br_taken = (opc == 4'b0000) && |(ir[11:9] & cc);

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (imem_ack) state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: state_nxt = (opc == 4'b1111) ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= 6'd0;
      cc            <= 3'b010;
      ir            <= 16'd0;
      alu_op        <= 2'b00;
      source_sel    <= 2'b00;
      ins_immediate <= 6'd0;
      rf_sr1        <= 3'd0;
      rf_sr2        <= 3'd0;
      rf_dr         <= 3'd0;
      we_q          <= 1'b0;
      ill_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + 6'd1;
      end
      if (state == DECODE) begin
        alu_op        <= dec_op;
        source_sel    <= dec_src;
        ins_immediate <= ir[5:0];
        rf_sr1        <= ir[8:6];
        rf_sr2        <= ir[2:0];
        rf_dr         <= ir[11:9];
        we_q          <= dec_we;
        ill_q         <= dec_ill;
      end
      if (state == EXECUTE) begin
        if (we_q)     cc <= {negative, zero, positive};
        if (br_taken) pc <= ir[5:0];
      end
    end
  end

  // rst gates strobes combinationally so the reset cycle is quiet
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;
  assign rf_we     = (state == EXECUTE) && we_q && !rst;
  assign illegal   = (state == EXECUTE) && ill_q && !rst;
  assign halted    = (state == HALT) && !rst;

endmodule
